// File: rtl/dmem_pkg.sv
// Shared data-memory constants and types for the dmem arbiter and its parent.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

   // Default geometry: 8 KiB data memory of 32-bit words.
   localparam int DMEMADDRBITS = 13;
   localparam int DMEMWORDBITS = 2;
   localparam int AW           = DMEMADDRBITS - DMEMWORDBITS;
   localparam int DBITS        = 8 << DMEMWORDBITS;

   // Longest run of lost contended cycles port 1 tolerates before it is forced in.
   localparam int STARVELIMIT  = 4;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_e;

   // Which port (if any) owns the read data returning from memory this cycle.
   typedef struct packed {
      logic  valid;
      port_e port;
   } rdtrack_t;

   // Width needed for a counter that must be able to hold 'limit'.
   function automatic int cnt_bits(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory (port 0 = CPU, port 1 = IO/DMA).
// Latency: grant is combinational in the request cycle; read data returns with rvalid one cycle after grant.
// Backpressure: requester holds req/we/addr/wdata until gnt; port 0 has priority, port 1 is forced in after STARVELIMIT lost cycles.
//
// Ports:
//   clk, reset                 clock (posedge) and asynchronous active-high reset
//   pN_req/we/addr/wdata       request, write enable, word address, write data of port N
//   pN_gnt                     access accepted this cycle (at most one port)
//   pN_rvalid                  read data for port N is on rdata this cycle
//   rdata                      read data, zero when neither rvalid is high
//   mem_wrtEn/mem_addr/mem_in  command to the memory, sourced from the granted port
//   mem_out                    memory read data, one cycle after the address was issued
module dmem_arbiter #(
   parameter int DMEMADDRBITS = dmem_pkg::DMEMADDRBITS,
   parameter int DMEMWORDBITS = dmem_pkg::DMEMWORDBITS,
   parameter int DBITS        = 8 << DMEMWORDBITS,
   parameter int STARVELIMIT  = dmem_pkg::STARVELIMIT
) (
   input  logic                                 clk,
   input  logic                                 reset,

   input  logic                                 p0_req,
   input  logic                                 p0_we,
   input  logic [DMEMADDRBITS-DMEMWORDBITS-1:0] p0_addr,
   input  logic [DBITS-1:0]                     p0_wdata,
   output logic                                 p0_gnt,
   output logic                                 p0_rvalid,

   input  logic                                 p1_req,
   input  logic                                 p1_we,
   input  logic [DMEMADDRBITS-DMEMWORDBITS-1:0] p1_addr,
   input  logic [DBITS-1:0]                     p1_wdata,
   output logic                                 p1_gnt,
   output logic                                 p1_rvalid,

   output logic [DBITS-1:0]                     rdata,

   output logic                                 mem_wrtEn,
   output logic [DMEMADDRBITS-DMEMWORDBITS-1:0] mem_addr,
   output logic [DBITS-1:0]                     mem_in,
   input  logic [DBITS-1:0]                     mem_out
);

   import dmem_pkg::*;

   localparam int CNTW = cnt_bits(STARVELIMIT);
   localparam logic [CNTW-1:0] CNT_MAX = CNTW'(STARVELIMIT);

   logic [CNTW-1:0] starve_cnt;
   logic            p1_force;
   logic            p1_win;
   logic            rd_grant;
   rdtrack_t        rd_trk;

   // ------------------------------------------------------------------
   // Arbitration. Port 0 wins ties unless port 1 has already lost
   // STARVELIMIT cycles in a row. Grants are held low through reset so the
   // memory never sees a command while the tracking state is being cleared.
   // ------------------------------------------------------------------
   always_comb begin
      p1_force = (starve_cnt == CNT_MAX);
      p1_win   = p1_req && (!p0_req || p1_force);
      p1_gnt   = !reset && p1_win;
      p0_gnt   = !reset && p0_req && !p1_win;
   end

   // ------------------------------------------------------------------
   // Memory command mux. Address/data follow port 0 when nothing is granted;
   // only the write enable needs to be qualified.
   // ------------------------------------------------------------------
   always_comb begin
      mem_addr  = p1_gnt ? p1_addr  : p0_addr;
      mem_in    = p1_gnt ? p1_wdata : p0_wdata;
      mem_wrtEn = (p0_gnt && p0_we) || (p1_gnt && p1_we);
      rd_grant  = (p0_gnt && !p0_we) || (p1_gnt && !p1_we);
   end

   // ------------------------------------------------------------------
   // Starvation counter: counts consecutive cycles port 1 waits. A withdrawn
   // request restarts the count, so a later request waits the full limit.
   // Saturation is defensive: at the limit port 1 always wins.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (!p1_req || p1_gnt) begin
         starve_cnt <= '0;
      end else if (!p1_force) begin
         starve_cnt <= starve_cnt + CNTW'(1);
      end
   end

   // ------------------------------------------------------------------
   // Read tracking: remembers which port issued last cycle's read so the
   // memory's one-cycle-late data is steered to the right requester. One
   // entry is enough because memory latency is exactly one cycle, which lets
   // alternating reads from both ports run every cycle.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_trk <= '{valid: 1'b0, port: PORT0};
      end else begin
         rd_trk.valid <= rd_grant;
         rd_trk.port  <= p1_gnt ? PORT1 : PORT0;
      end
   end

   always_comb begin
      p0_rvalid = rd_trk.valid && (rd_trk.port == PORT0);
      p1_rvalid = rd_trk.valid && (rd_trk.port == PORT1);
      // Zeroed when idle so rdata is clean during and right after reset.
      rdata     = rd_trk.valid ? mem_out : '0;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous memory model.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_arbiter;

   localparam int AW = 11;
   localparam int DW = 32;

   logic          clk;
   logic          reset;
   logic          p0_req, p0_we, p1_req, p1_we;
   logic [AW-1:0] p0_addr, p1_addr;
   logic [DW-1:0] p0_wdata, p1_wdata;
   logic          p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
   logic [DW-1:0] rdata;
   logic          mem_wrtEn;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_in;
   logic [DW-1:0] mem_out;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int n_checks = 0;
   int n_fail   = 0;

   dmem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .p0_req    (p0_req),
      .p0_we     (p0_we),
      .p0_addr   (p0_addr),
      .p0_wdata  (p0_wdata),
      .p0_gnt    (p0_gnt),
      .p0_rvalid (p0_rvalid),
      .p1_req    (p1_req),
      .p1_we     (p1_we),
      .p1_addr   (p1_addr),
      .p1_wdata  (p1_wdata),
      .p1_gnt    (p1_gnt),
      .p1_rvalid (p1_rvalid),
      .rdata     (rdata),
      .mem_wrtEn (mem_wrtEn),
      .mem_addr  (mem_addr),
      .mem_in    (mem_in),
      .mem_out   (mem_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Synchronous single-port memory, read-before-write, one-cycle read latency.
   always @(posedge clk) begin
      if (mem_wrtEn) mem[mem_addr] <= mem_in;
      mem_out <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      p0_req = 1'b0; p0_we = 1'b0;
      p1_req = 1'b0; p1_we = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle();
      p0_addr = '0; p0_wdata = '0;
      p1_addr = '0; p1_wdata = '0;

      // ---- reset: no grants or write enable even with both requesting ----
      #2;
      p0_req = 1'b1; p0_we = 1'b1; p1_req = 1'b1; p1_we = 1'b1;
      #1;
      check("rst_gnt0", p0_gnt, 0);
      check("rst_gnt1", p1_gnt, 0);
      check("rst_wrten", mem_wrtEn, 0);
      tick();
      tick();
      check("rst_rv0", p0_rvalid, 0);
      check("rst_rv1", p1_rvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_cnt", dut.starve_cnt, 0);
      idle();
      reset = 1'b0;

      // ---- port 0 write then read of addr 5, first cycle after release ----
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 11'd5; p0_wdata = 32'hDEADBEEF;
      #1;
      check("wr_gnt0", p0_gnt, 1);
      check("wr_gnt1", p1_gnt, 0);
      check("wr_wrten", mem_wrtEn, 1);
      check("wr_addr", mem_addr, 5);
      check("wr_din", mem_in, 32'hDEADBEEF);
      tick();
      check("wr_norv", p0_rvalid, 0);
      p0_we = 1'b0;
      #1;
      check("rd_gnt0", p0_gnt, 1);
      check("rd_wrten", mem_wrtEn, 0);
      tick();
      idle();
      check("rd_rv0", p0_rvalid, 1);
      check("rd_rv1", p1_rvalid, 0);
      check("rd_data", rdata, 32'hDEADBEEF);
      tick();
      check("rd_rvclr", p0_rvalid, 0);

      // ---- preload addr 1 / addr 2 through port 0 ----
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 11'd1; p0_wdata = 32'h11;
      tick();
      p0_addr = 11'd2; p0_wdata = 32'h22;
      tick();
      idle();

      // ---- alternating back-to-back reads: p0 addr1, p1 addr2 ----
      p0_addr = 11'd1; p1_addr = 11'd2;
      for (int i = 0; i < 6; i++) begin
         p0_req = (i % 2 == 0);
         p1_req = (i % 2 == 1);
         #1;
         check($sformatf("alt_gnt0_%0d", i), p0_gnt, (i % 2 == 0));
         check($sformatf("alt_gnt1_%0d", i), p1_gnt, (i % 2 == 1));
         if (i > 0) begin
            check($sformatf("alt_rv0_%0d", i), p0_rvalid, (i % 2 == 1));
            check($sformatf("alt_rv1_%0d", i), p1_rvalid, (i % 2 == 0));
            check($sformatf("alt_data_%0d", i), rdata, (i % 2 == 1) ? 32'h11 : 32'h22);
         end
         tick();
      end
      idle();
      check("alt_rv1_last", p1_rvalid, 1);
      check("alt_data_last", rdata, 32'h22);
      tick();

      // ---- port 1 writes 0x7FF, port 0 reads it the next cycle ----
      p1_req = 1'b1; p1_we = 1'b1; p1_addr = 11'h7FF; p1_wdata = 32'hA5A5A5A5;
      #1;
      check("wr1_gnt1", p1_gnt, 1);
      check("wr1_gnt0", p0_gnt, 0);
      check("wr1_wrten", mem_wrtEn, 1);
      check("wr1_addr", mem_addr, 11'h7FF);
      check("wr1_din", mem_in, 32'hA5A5A5A5);
      tick();
      idle();
      p0_req = 1'b1; p0_addr = 11'h7FF;
      #1;
      check("raw_gnt0", p0_gnt, 1);
      check("raw_norv1", p1_rvalid, 0);
      tick();
      idle();
      check("raw_rv0", p0_rvalid, 1);
      check("raw_data", rdata, 32'hA5A5A5A5);
      tick();

      // ---- continuous contention: p1 gets one grant in every five ----
      p0_req = 1'b1; p0_addr = 11'd1;
      p1_req = 1'b1; p1_addr = 11'd2;
      for (int i = 0; i < 15; i++) begin
         #1;
         check($sformatf("con_gnt1_%0d", i), p1_gnt, (i % 5 == 4));
         check($sformatf("con_gnt0_%0d", i), p0_gnt, (i % 5 != 4));
         check($sformatf("con_both_%0d", i), p0_gnt & p1_gnt, 0);
         if (i > 0)
            check($sformatf("con_data_%0d", i), rdata, ((i - 1) % 5 == 4) ? 32'h22 : 32'h11);
         tick();
      end
      idle();
      check("con_rv1_last", p1_rvalid, 1);
      tick();

      // ---- p1 waits 3 cycles, withdraws, then must wait the full limit again ----
      p0_req = 1'b1; p1_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("wd_gnt1_%0d", i), p1_gnt, 0);
         tick();
         check($sformatf("wd_cnt_%0d", i), dut.starve_cnt, i + 1);
      end
      p1_req = 1'b0;
      tick();
      check("wd_cnt_clr", dut.starve_cnt, 0);
      p1_req = 1'b1;
      for (int j = 0; j < 5; j++) begin
         #1;
         check($sformatf("wd2_gnt1_%0d", j), p1_gnt, (j == 4));
         check($sformatf("wd2_gnt0_%0d", j), p0_gnt, (j != 4));
         tick();
      end
      check("wd2_cnt_after", dut.starve_cnt, 0);
      idle();
      tick();

      // ---- reset asserted while a p0 read is being granted ----
      p0_req = 1'b1; p1_req = 1'b1;
      tick();
      tick();
      check("rr_cnt_pre", dut.starve_cnt, 2);
      #1;
      check("rr_gnt0_pre", p0_gnt, 1);
      reset = 1'b1;
      #1;
      check("rr_gnt0_rst", p0_gnt, 0);
      check("rr_gnt1_rst", p1_gnt, 0);
      check("rr_cnt_rst", dut.starve_cnt, 0);
      tick();
      check("rr_rv0_rst", p0_rvalid, 0);
      idle();
      reset = 1'b0;
      #1;
      check("rr_rv0_rel", p0_rvalid, 0);
      check("rr_rdata_rel", rdata, 0);
      tick();
      check("rr_rv0_after", p0_rvalid, 0);
      check("rr_rv1_after", p1_rvalid, 0);
      check("rr_cnt_after", dut.starve_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
